// File: rtl/bla_subtractor_pipe.sv
// Two-stage pipelined 8-bit borrow-lookahead subtractor on a valid/ready stream.
// Stage 1 resolves the low nibble and its group borrow; stage 2 finishes the high nibble and flags.
module bla_subtractor_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] diff,
    output logic       bout,
    output logic       ovf,
    output logic       zero
);

    // One 4-bit lookahead group: returns {group borrow-out, nibble difference}.
    function automatic logic [4:0] nib_sub(input logic [3:0] x, input logic [3:0] y,
                                           input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        logic       grp_g;
        logic       grp_p;
        g     = ~x & y;
        p     = ~(x ^ y);
        c[0]  = cin;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        grp_p = &p;
        c[4]  = grp_g | (grp_p & c[0]);
        return {c[4], x ^ y ^ c[3:0]};
    endfunction

    logic       s1_valid;
    logic [3:0] s1_diff_lo;
    logic       s1_c4;
    logic [3:0] s1_a_hi;
    logic [3:0] s1_b_hi;

    logic [4:0] lo_res;
    logic [4:0] hi_res;
    logic       s2_free;
    logic       s1_load;

    always_comb begin
        lo_res  = nib_sub(a[3:0], b[3:0], bin);
        hi_res  = nib_sub(s1_a_hi, s1_b_hi, s1_c4);
        s2_free = !out_valid || out_ready;
        // in_ready must never look at in_valid, or upstream could form a combinational loop.
        in_ready = !rst && (!s1_valid || s2_free);
        s1_load  = in_valid && in_ready;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let stage 2 see stage 1's new contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_diff_lo <= 4'h0;
            s1_c4      <= 1'b0;
            s1_a_hi    <= 4'h0;
            s1_b_hi    <= 4'h0;
            out_valid  <= 1'b0;
            diff       <= 8'h00;
            bout       <= 1'b0;
            ovf        <= 1'b0;
            zero       <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid   <= 1'b1;
                s1_diff_lo <= lo_res[3:0];
                s1_c4      <= lo_res[4];
                s1_a_hi    <= a[7:4];
                s1_b_hi    <= b[7:4];
            end else if (s1_valid && s2_free) begin
                s1_valid <= 1'b0;
            end

            // Output register advances only when free; an empty S1 with a pop drops out_valid.
            if (s2_free) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    diff <= {hi_res[3:0], s1_diff_lo};
                    bout <= hi_res[4];
                    ovf  <= (s1_a_hi[3] != s1_b_hi[3]) && (hi_res[3] != s1_a_hi[3]);
                    zero <= ({hi_res[3:0], s1_diff_lo} == 8'h00);
                end
            end
        end
    end

endmodule

// File: tb/tb_bla_subtractor_pipe.sv
// Scoreboard bench for bla_subtractor_pipe: the driver records expected results on accept,
// and an independent monitor pops and compares whenever a result beat is consumed.
module tb_bla_subtractor_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;

    logic [10:0] exp_pkt;   // {diff, bout, ovf, zero} for the operands currently driven
    logic [10:0] sb[$];
    int          pass_cnt;
    int          total_cnt;
    bit          rand_done;

    bla_subtractor_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .ovf      (ovf),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y,
                                          input logic c);
        logic [8:0] r;
        logic       v;
        r = {1'b0, x} - {1'b0, y} - {8'h00, c};
        v = (x[7] != y[7]) && (r[7] != x[7]);
        return {r[7:0], r[8], v, (r[7:0] == 8'h00)};
    endfunction

    // Accept side of the scoreboard: a beat is taken at the next rising edge.
    always @(negedge clk) begin
        if (in_valid && in_ready)
            sb.push_back(exp_pkt);
    end

    // Monitor: compare each result beat that the consumer takes at the next edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                logic [10:0] e;
                e = sb.pop_front();
                check("result", {21'd0, diff, bout, ovf, zero}, {21'd0, e});
            end
        end
    end

    // Present one beat and hold it until accepted; returns just after the accepting edge.
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic c,
                         input logic [10:0] e);
        int waited;
        a        = x;
        b        = y;
        bin      = c;
        exp_pkt  = e;
        in_valid = 1'b1;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 1000) begin
                check("issue_timeout", {31'd0, in_ready}, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_idle_flags(input string tag);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_diff"}, {24'd0, diff}, 32'h00);
        check({tag, "_flags"}, {29'd0, bout, ovf, zero}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rand_done = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 8'h50;
        b         = 8'h20;
        bin       = 1'b0;
        exp_pkt   = 11'h0;

        // Reset held for two cycles with in_valid asserted.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check_idle_flags("reset");
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            check("post_reset_no_beat", {31'd0, out_valid}, 32'd0);
        end

        // Basic beat with latency check.
        @(posedge clk);
        #1;
        issue(8'h50, 8'h20, 1'b0, {8'h30, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        check("latency_n1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency_n2", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Borrow and flag corners, back-to-back.
        issue(8'h00, 8'h01, 1'b0, {8'hFF, 1'b1, 1'b0, 1'b0});
        issue(8'h80, 8'h01, 1'b0, {8'h7F, 1'b0, 1'b1, 1'b0});
        issue(8'h10, 8'h0F, 1'b1, {8'h00, 1'b0, 1'b0, 1'b1});
        issue(8'h00, 8'hFF, 1'b1, {8'h00, 1'b1, 1'b0, 1'b1});
        repeat (4) @(posedge clk);
        #1;
        check("corners_drained", sb.size(), 32'd0);

        // Backpressure: two beats fill the pipe, the third is refused until release.
        out_ready = 1'b0;
        issue(8'h05, 8'h01, 1'b0, {8'h04, 1'b0, 1'b0, 1'b0});
        issue(8'h06, 8'h01, 1'b0, {8'h05, 1'b0, 1'b0, 1'b0});
        fork
            issue(8'h07, 8'h01, 1'b0, {8'h06, 1'b0, 1'b0, 1'b0});
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                    check("bp_hold_diff", {24'd0, diff}, 32'h04);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("bp_drain_valid", {31'd0, out_valid}, 32'd1);
                end
                @(negedge clk);
                check("bp_drain_done", {31'd0, out_valid}, 32'd0);
            end
        join
        @(posedge clk);
        #1;

        // Reset mid-flight: both in-flight beats must vanish.
        out_ready = 1'b0;
        issue(8'h33, 8'h11, 1'b0, {8'h22, 1'b0, 1'b0, 1'b0});
        issue(8'h44, 8'h11, 1'b0, {8'h33, 1'b0, 1'b0, 1'b0});
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (5) @(negedge clk);
        check("midreset_quiet", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Random operands, random gaps on the input and random backpressure.
        fork
            begin
                for (int n = 0; n < 2000; n++) begin
                    logic [7:0] x;
                    logic [7:0] y;
                    logic       c;
                    repeat ($urandom_range(0, 2)) begin
                        a = 8'($urandom);
                        b = 8'($urandom);
                        @(posedge clk);
                        #1;
                    end
                    x = 8'($urandom);
                    y = 8'($urandom);
                    c = 1'($urandom);
                    issue(x, y, c, model(x, y, c));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check("random_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
